// File: rtl/saa_video_tx_if.sv
// Pixel-side bus of the SAA7111A-style transmitter: frame buffer read port,
// field controls and the timed YCbCr output.
interface saa_video_tx_if;
   logic        en;
   logic        bank_sel;
   logic        rd_en;
   logic [15:0] rd_addr;
   logic [15:0] rd_data;
   logic        href;
   logic        vref;
   logic        odd;
   logic [15:0] vpo;
   logic        frame_irq;

   modport master (
      input  en, bank_sel, rd_data,
      output rd_en, rd_addr, href, vref, odd, vpo, frame_irq
   );

   modport slave (
      output en, bank_sel, rd_data,
      input  rd_en, rd_addr, href, vref, odd, vpo, frame_irq
   );
endinterface

// File: rtl/saa_video_tx.sv
// SAA7111A-style interlaced transmitter: timing generator, 4x/2x upscaling
// frame buffer reader and RGB565 to YCbCr 4:2:2 conversion, 3-clock latency.
module saa_video_tx #(
   parameter int H_ACTIVE     = 720,
   parameter int H_TOTAL      = 858,
   parameter int V_START      = 20,
   parameter int V_ACTIVE     = 240,
   parameter int V_TOTAL_ODD  = 263,
   parameter int V_TOTAL_EVEN = 262,
   parameter int IMG_W        = 180
) (
   input  logic           clk_llc2,
   input  logic           resetx,
   saa_video_tx_if.master bus
);

   localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]  H_ACT    = 10'(H_ACTIVE);
   localparam logic [8:0]  V_FIRST  = 9'(V_START);
   localparam logic [8:0]  V_END    = 9'(V_START + V_ACTIVE);
   localparam logic [8:0]  VO_LAST  = 9'(V_TOTAL_ODD - 1);
   localparam logic [8:0]  VE_LAST  = 9'(V_TOTAL_EVEN - 1);
   localparam logic [14:0] ROW_STEP = 15'(IMG_W);
   localparam logic [15:0] BLANK    = 16'h1080;

   localparam logic signed [17:0] K_YR = 18'sd66;
   localparam logic signed [17:0] K_YG = 18'sd129;
   localparam logic signed [17:0] K_YB = 18'sd25;
   localparam logic signed [17:0] K_UR = -18'sd38;
   localparam logic signed [17:0] K_UG = -18'sd74;
   localparam logic signed [17:0] K_UB = 18'sd112;
   localparam logic signed [17:0] K_VR = 18'sd112;
   localparam logic signed [17:0] K_VG = -18'sd94;
   localparam logic signed [17:0] K_VB = -18'sd18;

   function automatic logic signed [17:0] u8(input logic [7:0] x);
      return $signed({10'd0, x});
   endfunction

   // Round-to-nearest of the weighted sum, then arithmetic divide by 256.
   function automatic logic signed [17:0] scale(input logic signed [17:0] a,
                                                input logic signed [17:0] b,
                                                input logic signed [17:0] c);
      logic signed [17:0] s;
      s = a + b + c + 18'sd128;
      return s >>> 8;
   endfunction

   function automatic logic [7:0] sat8(input logic signed [17:0] v,
                                       input logic signed [17:0] lo,
                                       input logic signed [17:0] hi);
      if (v < lo)      return lo[7:0];
      else if (v > hi) return hi[7:0];
      else             return v[7:0];
   endfunction

   logic [9:0]  h_cnt_q, h_cnt_d;
   logic [8:0]  v_cnt_q, v_cnt_d;
   logic        field_q, field_d;
   logic [14:0] row_base_q, row_base_d, off_c;
   logic        bank_q, en_q;
   logic [15:0] addr_q, rd_addr_c;
   logic        h_wrap, v_wrap, line0, act0, fstart, rd_en0;
   logic        wrap_q;

   logic        rd_en_p1_q, act_p1_q, line_p1_q, fld_p1_q, ph_p1_q, irq_p1_q;
   logic [15:0] pix_q, pix_c;
   logic [7:0]  r8, g8, b8;

   logic signed [17:0] yr_p2_q, yg_p2_q, yb_p2_q;
   logic signed [17:0] ur_p2_q, ug_p2_q, ub_p2_q;
   logic signed [17:0] vr_p2_q, vg_p2_q, vb_p2_q;
   logic        act_p2_q, line_p2_q, fld_p2_q, ph_p2_q, irq_p2_q;

   logic [7:0]  y_c, cb_c, cr_c;
   logic [15:0] vpo_d, vpo_q;
   logic        href_q, vref_q, odd_q, irq_q;

   // Stage 0: raster counters, active region and read address.
   assign h_wrap = (h_cnt_q == H_LAST);
   assign v_wrap = h_wrap && (v_cnt_q == (field_q ? VO_LAST : VE_LAST));
   assign line0  = (v_cnt_q >= V_FIRST) && (v_cnt_q < V_END);
   assign act0   = line0 && (h_cnt_q < H_ACT);
   assign fstart = (h_cnt_q == 10'd0) && (v_cnt_q == 9'd0) && field_q;

   always_comb begin
      h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
      v_cnt_d = v_cnt_q;
      if (h_wrap)
         v_cnt_d = v_wrap ? 9'd0 : v_cnt_q + 9'd1;
      field_d = field_q ^ v_wrap;
   end

   // Each frame buffer row feeds two output lines; advance after the second.
   always_comb begin
      row_base_d = row_base_q;
      if (!line0)
         row_base_d = '0;
      else if (h_wrap && (v_cnt_q[0] ^ V_FIRST[0]))
         row_base_d = row_base_q + ROW_STEP;
   end

   assign rd_en0    = act0 && en_q && (h_cnt_q[1:0] == 2'b00);
   assign off_c     = row_base_q + {7'd0, h_cnt_q[9:2]};
   assign rd_addr_c = rd_en0 ? {bank_q, off_c} : addr_q;

   // Stage 1: hold the fetched word for all four output clocks of the pixel.
   assign pix_c = rd_en_p1_q ? bus.rd_data : pix_q;
   assign r8    = {pix_c[15:11], pix_c[15:13]};
   assign g8    = {pix_c[10:5],  pix_c[10:9]};
   assign b8    = {pix_c[4:0],   pix_c[4:2]};

   // Stage 3: sum, offset, clip, chroma phase select and blanking.
   assign y_c  = sat8(scale(yr_p2_q, yg_p2_q, yb_p2_q) + 18'sd16,  18'sd16, 18'sd235);
   assign cb_c = sat8(scale(ur_p2_q, ug_p2_q, ub_p2_q) + 18'sd128, 18'sd16, 18'sd240);
   assign cr_c = sat8(scale(vr_p2_q, vg_p2_q, vb_p2_q) + 18'sd128, 18'sd16, 18'sd240);
   assign vpo_d = (act_p2_q && line_p2_q && en_q) ? {y_c, ph_p2_q ? cr_c : cb_c} : BLANK;

   always_ff @(posedge clk_llc2 or negedge resetx) begin
      if (!resetx) begin
         h_cnt_q    <= '0;
         v_cnt_q    <= '0;
         field_q    <= 1'b1;
         row_base_q <= '0;
         bank_q     <= 1'b0;
         en_q       <= 1'b0;
         addr_q     <= '0;
         wrap_q     <= 1'b0;
         rd_en_p1_q <= 1'b0;
         act_p1_q   <= 1'b0;
         line_p1_q  <= 1'b0;
         fld_p1_q   <= 1'b0;
         ph_p1_q    <= 1'b0;
         irq_p1_q   <= 1'b0;
         pix_q      <= '0;
         yr_p2_q    <= '0;
         yg_p2_q    <= '0;
         yb_p2_q    <= '0;
         ur_p2_q    <= '0;
         ug_p2_q    <= '0;
         ub_p2_q    <= '0;
         vr_p2_q    <= '0;
         vg_p2_q    <= '0;
         vb_p2_q    <= '0;
         act_p2_q   <= 1'b0;
         line_p2_q  <= 1'b0;
         fld_p2_q   <= 1'b0;
         ph_p2_q    <= 1'b0;
         irq_p2_q   <= 1'b0;
         vpo_q      <= BLANK;
         href_q     <= 1'b0;
         vref_q     <= 1'b0;
         odd_q      <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         h_cnt_q    <= h_cnt_d;
         v_cnt_q    <= v_cnt_d;
         field_q    <= field_d;
         row_base_q <= row_base_d;
         addr_q     <= rd_addr_c;
         wrap_q     <= v_wrap && !field_q;
         if (fstart) begin
            bank_q <= bus.bank_sel;
            en_q   <= bus.en;
         end
         rd_en_p1_q <= rd_en0;
         act_p1_q   <= act0;
         line_p1_q  <= line0;
         fld_p1_q   <= field_q;
         ph_p1_q    <= h_cnt_q[0];
         irq_p1_q   <= wrap_q;
         pix_q      <= pix_c;
         yr_p2_q    <= K_YR * u8(r8);
         yg_p2_q    <= K_YG * u8(g8);
         yb_p2_q    <= K_YB * u8(b8);
         ur_p2_q    <= K_UR * u8(r8);
         ug_p2_q    <= K_UG * u8(g8);
         ub_p2_q    <= K_UB * u8(b8);
         vr_p2_q    <= K_VR * u8(r8);
         vg_p2_q    <= K_VG * u8(g8);
         vb_p2_q    <= K_VB * u8(b8);
         act_p2_q   <= act_p1_q;
         line_p2_q  <= line_p1_q;
         fld_p2_q   <= fld_p1_q;
         ph_p2_q    <= ph_p1_q;
         irq_p2_q   <= irq_p1_q;
         vpo_q      <= vpo_d;
         href_q     <= act_p2_q;
         vref_q     <= line_p2_q;
         odd_q      <= fld_p2_q;
         irq_q      <= irq_p2_q;
      end
   end

   assign bus.rd_en     = rd_en0;
   assign bus.rd_addr   = rd_addr_c;
   assign bus.href      = href_q;
   assign bus.vref      = vref_q;
   assign bus.odd       = odd_q;
   assign bus.vpo       = vpo_q;
   assign bus.frame_irq = irq_q;

endmodule

// File: tb/tb_saa_video_tx.sv
// Bench for saa_video_tx on a reduced raster; a frame-position reference model
// predicts every output on every clock.
module tb_saa_video_tx;
   localparam int HT    = 40;
   localparam int HA    = 32;
   localparam int VS    = 3;
   localparam int VA    = 6;
   localparam int VO    = 11;
   localparam int VE    = 10;
   localparam int IW    = 8;
   localparam int FRAME = (VO + VE) * HT;

   logic clk    = 1'b0;
   logic resetx = 1'b0;
   always #5 clk = ~clk;

   saa_video_tx_if bus();

   saa_video_tx #(
      .H_ACTIVE(HA), .H_TOTAL(HT), .V_START(VS), .V_ACTIVE(VA),
      .V_TOTAL_ODD(VO), .V_TOTAL_EVEN(VE), .IMG_W(IW)
   ) dut (
      .clk_llc2 (clk),
      .resetx   (resetx),
      .bus      (bus)
   );

   logic [15:0] mem [0:65535];
   always @(posedge clk)
      if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

   int          n_tests = 0;
   int          n_fail  = 0;
   int          t       = 0;
   int          gframe  = 0;
   logic [15:0] last_addr;
   bit          en_hist   [0:15];
   bit          bank_hist [0:15];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         if (n_fail <= 25)
            $display("FAIL %s at t=%0d (%0t): got %h, expected %h", tag, t, $time, got, exp);
      end
   endtask

   function automatic void decode(input int s, output bit fl, output int v, output int h);
      int p, line;
      p    = s % FRAME;
      line = p / HT;
      h    = p % HT;
      if (line < VO) begin fl = 1'b1; v = line;      end
      else           begin fl = 1'b0; v = line - VO; end
   endfunction

   function automatic bit is_line(input int v);
      return (v >= VS) && (v < VS + VA);
   endfunction

   function automatic logic [15:0] addr_of(input bit b, input int v, input int h);
      return 16'(int'(b) * 32768 + ((v - VS) / 2) * IW + h / 4);
   endfunction

   function automatic int clip(input int v, input int lo, input int hi);
      return (v < lo) ? lo : (v > hi) ? hi : v;
   endfunction

   function automatic logic [15:0] conv(input logic [15:0] px, input bit ph);
      int r, g, b, y, cb, cr;
      r  = int'(px[15:11]); r = r * 8 + r / 4;
      g  = int'(px[10:5]);  g = g * 4 + g / 16;
      b  = int'(px[4:0]);   b = b * 8 + b / 4;
      y  = clip(16  + ((66 * r + 129 * g + 25 * b + 128) >>> 8), 16, 235);
      cb = clip(128 + ((-38 * r - 74 * g + 112 * b + 128) >>> 8), 16, 240);
      cr = clip(128 + ((112 * r - 94 * g - 18 * b + 128) >>> 8), 16, 240);
      return {8'(y), 8'(ph ? cr : cb)};
   endfunction

   task automatic fill(input bit rnd, input logic [15:0] val);
      for (int b = 0; b < 2; b++)
         for (int o = 0; o < (VA / 2) * IW; o++)
            mem[16'(b * 32768 + o)] = rnd ? 16'($urandom) : val;
   endtask

   task automatic apply_sched(input int g);
      case (g)
         0:       begin fill(1'b0, 16'hFFFF); bus.en = 1'b1; bus.bank_sel = 1'b0; end
         1:       begin fill(1'b0, 16'h0000); bus.en = 1'b1; bus.bank_sel = 1'b1; end
         2:       begin fill(1'b0, 16'hF800); bus.en = 1'b1; bus.bank_sel = 1'b0; end
         5:       begin fill(1'b1, 16'h0000); bus.en = 1'b0; bus.bank_sel = 1'($urandom_range(0, 1)); end
         default: begin fill(1'b1, 16'h0000); bus.en = 1'b1; bus.bank_sel = 1'(g % 2); end
      endcase
   endtask

   task automatic check_reset(input string tag);
      chk({tag, ".rd_en"},     32'(bus.rd_en),     32'd0);
      chk({tag, ".rd_addr"},   32'(bus.rd_addr),   32'd0);
      chk({tag, ".href"},      32'(bus.href),      32'd0);
      chk({tag, ".vref"},      32'(bus.vref),      32'd0);
      chk({tag, ".odd"},       32'(bus.odd),       32'd0);
      chk({tag, ".vpo"},       32'(bus.vpo),       32'h1080);
      chk({tag, ".frame_irq"}, 32'(bus.frame_irq), 32'd0);
   endtask

   task automatic cycle_body();
      int          f, s, v, h;
      bit          fl, e_rd, e_href, e_vref, e_odd, e_irq;
      logic [15:0] e_vpo;
      f = t / FRAME;
      if (t % FRAME == 0) begin
         apply_sched(gframe);
         en_hist[f]   = bus.en;
         bank_hist[f] = bus.bank_sel;
         gframe++;
      end else begin
         if ($urandom_range(0, 49) == 0) bus.en       = ~bus.en;
         if ($urandom_range(0, 49) == 0) bus.bank_sel = ~bus.bank_sel;
      end

      decode(t, fl, v, h);
      e_rd = is_line(v) && (h < HA) && en_hist[f] && (h % 4 == 0);
      if (e_rd) last_addr = addr_of(bank_hist[f], v, h);
      chk("rd_en",   32'(bus.rd_en),   32'(e_rd));
      chk("rd_addr", 32'(bus.rd_addr), 32'(last_addr));

      s = t - 3;
      if (s < 0) begin
         e_href = 1'b0; e_vref = 1'b0; e_odd = 1'b0; e_irq = 1'b0; e_vpo = 16'h1080;
      end else begin
         decode(s, fl, v, h);
         e_vref = is_line(v);
         e_href = e_vref && (h < HA);
         e_odd  = fl;
         e_irq  = (s % FRAME == 0) && (s >= FRAME);
         if (e_href && en_hist[s / FRAME])
            e_vpo = conv(mem[addr_of(bank_hist[s / FRAME], v, h)], 1'(h % 2));
         else
            e_vpo = 16'h1080;
      end
      chk("href",      32'(bus.href),      32'(e_href));
      chk("vref",      32'(bus.vref),      32'(e_vref));
      chk("odd",       32'(bus.odd),       32'(e_odd));
      chk("frame_irq", 32'(bus.frame_irq), 32'(e_irq));
      chk("vpo",       32'(bus.vpo),       32'(e_vpo));
   endtask

   task automatic run(input int n);
      repeat (n) begin
         cycle_body();
         @(posedge clk);
         t++;
         @(negedge clk);
      end
   endtask

   initial begin
      bus.en       = 1'b0;
      bus.bank_sel = 1'b0;
      last_addr    = 16'h0000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset("reset");
      resetx = 1'b1;
      t      = 0;

      // Run into the even field of the eighth frame, then reset mid-line.
      run(7 * FRAME + (VO + 3) * HT + 10);
      #2 resetx = 1'b0;
      #1 check_reset("midreset");
      repeat (2) @(negedge clk);
      check_reset("hold");
      resetx    = 1'b1;
      t         = 0;
      last_addr = 16'h0000;
      run(2 * FRAME + 30);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/saa_video_tx.md
Name: saa_video_tx

Overview:
- Transmit-side counterpart of the SAA7111A capture path.
- Generates SAA7111A-style interlaced timing (href, vref, odd) at 13.5 MHz.
- Reads the 180x120 RGB565 frame buffer from block RAM and upscales 4x horizontally and 2x vertically per field.
- Converts each pixel to 16-bit YCbCr 4:2:2 (Y on [15:8], Cb/Cr alternating on [7:0]) for an external video encoder or loopback into the capture path.

Parameters:
H_ACTIVE, 720, active pixels per line
H_TOTAL, 858, clocks per line
V_START, 20, first active line in a field
V_ACTIVE, 240, active lines per field
V_TOTAL_ODD, 263, lines in odd field
V_TOTAL_EVEN, 262, lines in even field
IMG_W, 180, frame buffer words per row

Ports:
clk_llc2  in  1  13.5 MHz pixel clock
resetx  in  1  async active-low reset
en  in  1  output enable, sampled at odd-field start
bank_sel  in  1  frame buffer bank, sampled at odd-field start
rd_en  out  1  RAM read strobe
rd_addr  out  16  RAM word address {bank, 15-bit offset}
rd_data  in  16  RGB565 from RAM, valid 1 cycle after rd_en
href  out  1  active-pixel flag
vref  out  1  active-line flag
odd  out  1  1 during odd field
vpo  out  16  {Y, Cb|Cr}
frame_irq  out  1  1-cycle pulse at end of even field

Behaviour:
- Interface: reset resetx, asynchronous, active-low; clock clk_llc2.
- Counters:
  - h_cnt runs 0..H_TOTAL-1, then wraps to 0 and advances v_cnt.
  - v_cnt runs 0..V_TOTAL_x-1, then wraps and toggles the internal field flag.
  - Field flag resets to odd. Odd field uses V_TOTAL_ODD; even field uses V_TOTAL_EVEN.
- Field-start latch: at h_cnt=0, v_cnt=0 of an odd field, latch bank_sel into bank_q and en into en_q. Both are held for the full frame (odd+even). Mid-frame changes are ignored.
- Active region (stage 0): act = h_cnt<H_ACTIVE and V_START<=v_cnt<V_START+V_ACTIVE.
- Addressing:
  - row_base register clears at v_cnt=V_START.
  - row_base adds IMG_W at end of every second active line (active line index bit0=1).
  - rd_en = act & en_q & h_cnt[1:0]==0.
  - rd_addr = {bank_q, row_base + h_cnt[9:2]}. Max offset 119*180+179 = 21599 (0x545F), never wraps.
  - When rd_en=0, rd_addr holds its last value.
- Pipeline, total latency 3 clocks from stage-0 counters to outputs:
  - S1: capture rd_data into pix when the previous cycle had rd_en. pix holds across the 4-clock pixel.
  - S2: expand R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}. Form signed products.
  - S3:
    - Y = 16 + ((66R+129G+25B+128)>>>8)
    - Cb = 128 + ((-38R-74G+112B+128)>>>8)
    - Cr = 128 + ((112R-94G-18B+128)>>>8)
    - Arithmetic shift, 18-bit signed intermediates.
    - Clip Y to 16..235 and C to 16..240.
- Chroma phase: h_cnt[0] delayed 3 clocks selects Cb (0) or Cr (1) on vpo[7:0].
- Outputs:
  - href, vref and the field flag are delayed 3 registers so they align with vpo.
  - href = act delayed 3. vref = line-active delayed 3. odd = field flag delayed 3.
- Blanking:
  - If href&vref=0, vpo=16'h1080.
  - If en_q=0, vpo=16'h1080 always, but timing signals still run.
- frame_irq: 1-cycle pulse, 3 clocks after the wrap from the last even-field line to the odd field.
- Reset values and mid-operation reset:
  - Reset values: h_cnt=0, v_cnt=0, field=odd, row_base=0, bank_q=0, en_q=0, pipeline cleared.
  - Outputs in reset: rd_en=0, rd_addr=0, href=0, vref=0, odd=0, vpo=16'h1080, frame_irq=0.
  - Reset mid-line drops all outputs to these values immediately. After release, timing restarts at line 0 of an odd field.
- Simultaneous events: h wrap, v wrap and field toggle resolve in the same cycle. The odd-field latch uses the post-wrap state.

Test Plan:
- Timing check, after reset with en=1: href high exactly 720 clocks per 858; vref high 240 lines per field; odd field 263 lines, even 262; odd toggles every field; frame_irq exactly once per 525 lines.
- Colour conversion: RAM constant 16'hFFFF -> vpo 16'hEB80 on active pixels; 16'h0000 -> 16'h1080; 16'hF800 -> Y=82 with Cb=90 on even pixels and Cr=240 on odd pixels.
- Addressing: rd_en pulses every 4 clocks (180 per active line). Line-pair k reads offsets k*180..k*180+179, and both lines of a pair read identical addresses. The last read is 0x545F. With bank_sel=1 latched, rd_addr[15]=1.
- Latch timing: toggle bank_sel and en mid-field -> no change until the next odd-field start. Then en=0 -> vpo=16'h1080 and rd_en=0 while href/vref keep toggling.
- Alignment: RAM word n = distinct value -> vpo changes exactly on href rise + 4k clocks. href rises 3 clocks after the stage-0 h_cnt=0.
- Reset mid-operation: assert resetx mid-line of the even field -> all outputs at reset values the same cycle. After release, the first href occurs at line V_START of an odd field.
